// File: rtl/resta_serial_pkg.sv
//------------------------------------------------------------------------------
// resta_serial_pkg : shared state encoding and default width | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package resta_serial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/resta_serial_if.sv
//------------------------------------------------------------------------------
// resta_serial_if : start/busy/done handshake and operand/result bus | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface resta_serial_if
  import resta_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             neg;

  modport master (output start, a, b, input busy, done, diff, neg);
  modport slave  (input start, a, b, output busy, done, diff, neg);

endinterface

`default_nettype wire

// File: rtl/resta_1.sv
//------------------------------------------------------------------------------
// resta_1 : combinational 1-bit full subtractor | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module resta_1 (
  input  wire logic a_i,
  input  wire logic b_i,
  input  wire logic bin_i,
  output logic      d_o,
  output logic      bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);

endmodule

`default_nettype wire

// File: rtl/resta_serial.sv
//------------------------------------------------------------------------------
// resta_serial : bit-serial |a - b| with sign flag, LSB first | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module resta_serial
  import resta_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  resta_serial_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d, neg_q, neg_d;
  logic             cell_x, cell_y, cell_d, cell_bout;
  logic [WIDTH-1:0] r_shift;

  // NEG pass computes 0 - R through the same cell
  assign cell_x  = (state_q == NEG) ? 1'b0 : sa_q[0];
  assign cell_y  = (state_q == NEG) ? r_q[0] : sb_q[0];
  assign r_shift = {cell_d, r_q[WIDTH-1:1]};

  resta_1 u_cell (
    .a_i    (cell_x),
    .b_i    (cell_y),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d     = bus.a;
          sb_d     = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SUB;
        end
      end
      SUB: begin
        r_d      = r_shift;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          if (cell_bout) begin
            borrow_d = 1'b0;
            cnt_d    = '0;
            state_d  = NEG;
          end else begin
            diff_d  = r_shift;
            neg_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      NEG: begin
        r_d      = r_shift;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = r_shift;
          neg_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
    end
  end

  // Result registers load on entry to DONE, so done and diff/neg align
  assign bus.busy = (state_q == SUB) || (state_q == NEG);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.neg  = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_resta_serial.sv
//------------------------------------------------------------------------------
// tb_resta_serial : directed self-checking bench for resta_serial | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_resta_serial;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  resta_serial_if #(.WIDTH(W)) bus ();

  resta_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept edge is cycle 0; cycle k is sampled at the negedge after edge k-1.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int ed, input int en, input int ecyc, input int inj);
    logic [W-1:0] prev;
    logic [W-1:0] got_diff;
    logic         got_neg;
    int           done_cyc;
    int           busy_bad;
    int           hold_bad;
    prev     = bus.diff;
    got_diff = '0;
    got_neg  = 1'b0;
    done_cyc = 0;
    busy_bad = 0;
    hold_bad = 0;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == inj) begin
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        got_diff = bus.diff;
        got_neg  = bus.neg;
        if (bus.busy !== 1'b0) busy_bad++;
      end else begin
        if (bus.busy !== 1'b1) busy_bad++;
        if (bus.diff !== prev) hold_bad++;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_cycle"}, done_cyc, ecyc);
    check_eq({tag, "_diff"}, int'(got_diff), ed);
    check_eq({tag, "_neg"}, int'(got_neg), en);
    check_eq({tag, "_busy_profile"}, busy_bad, 0);
    check_eq({tag, "_diff_hold"}, hold_bad, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, int'(bus.done), 0);
    check_eq({tag, "_diff_after"}, int'(bus.diff), ed);
  endtask

  initial begin
    int done_at[3];
    int n_done;
    int stab_bad;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_diff", int'(bus.diff), 0);
    check_eq("rst_neg", int'(bus.neg), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("200m55", 8'd200, 8'd55, 145, 0, 9, 0);
    run_op("55m200", 8'd55, 8'd200, 145, 1, 17, 0);
    run_op("255m0", 8'd255, 8'd0, 255, 0, 9, 0);
    run_op("77m77", 8'd77, 8'd77, 0, 0, 9, 0);
    run_op("100m30_inj", 8'd100, 8'd30, 70, 0, 9, 4);
    run_op("0m255", 8'd0, 8'd255, 255, 1, 17, 0);

    // Async reset in the middle of 10 - 20
    bus.a     = 8'd10;
    bus.b     = 8'd20;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_busy_before_rst", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(bus.busy), 0);
    check_eq("mid_rst_done", int'(bus.done), 0);
    check_eq("mid_rst_diff", int'(bus.diff), 0);
    check_eq("mid_rst_neg", int'(bus.neg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("9m4", 8'd9, 8'd4, 5, 0, 9, 0);

    // start held high: back-to-back 9 - 3 every WIDTH+2 cycles
    n_done   = 0;
    stab_bad = 0;
    bus.a     = 8'd9;
    bus.b     = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (n_done < 3) done_at[n_done] = cyc;
        n_done++;
        if (bus.diff !== 8'd6) stab_bad++;
      end else if (n_done > 0 && bus.diff !== 8'd6) begin
        stab_bad++;
      end
    end
    bus.start = 1'b0;
    check_eq("cont_done_count", n_done, 3);
    check_eq("cont_done_1", (n_done > 0) ? done_at[0] : -1, 9);
    check_eq("cont_done_2", (n_done > 1) ? done_at[1] : -1, 19);
    check_eq("cont_done_3", (n_done > 2) ? done_at[2] : -1, 29);
    check_eq("cont_diff_stable", stab_bad, 0);
    repeat (12) @(negedge clk);
    check_eq("final_idle_busy", int'(bus.busy), 0);
    check_eq("final_diff", int'(bus.diff), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
